// File: rtl/mips_pkg.sv
// Shared MIPS decode constants, ALU operation encodings and stage state type
// for the ID/EX ALU-control stage.
package mips_pkg;

    localparam logic [5:0] OPC_RTYPE  = 6'h00;
    localparam logic [5:0] OPC_ADDI   = 6'h08;
    localparam logic [5:0] OPC_SLTI   = 6'h0A;
    localparam logic [5:0] OPC_ANDI   = 6'h0C;
    localparam logic [5:0] OPC_ORI    = 6'h0D;

    localparam logic [5:0] FUNCT_ADD  = 6'h20;
    localparam logic [5:0] FUNCT_SUB  = 6'h22;
    localparam logic [5:0] FUNCT_AND  = 6'h24;
    localparam logic [5:0] FUNCT_OR   = 6'h25;
    localparam logic [5:0] FUNCT_SLT  = 6'h2A;

    typedef enum logic [1:0] {
        ALU_AND = 2'b00,
        ALU_OR  = 2'b01,
        ALU_ADD = 2'b10
    } alu_op_e;

    typedef enum logic {
        EXT_ZERO = 1'b0,
        EXT_SIGN = 1'b1
    } ext_mode_e;

    typedef enum logic {
        BSEL_RT  = 1'b0,
        BSEL_IMM = 1'b1
    } b_sel_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_HALF  = 2'b01,
        ST_FULL  = 2'b10
    } stage_state_e;

endpackage

// File: rtl/id_ex_alu_stage_if.sv
// Bundles the upstream/downstream handshake and payload of the ID/EX ALU stage;
// master drives instructions and accepts results, slave is the stage itself.
interface id_ex_alu_stage_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [5:0]        in_opcode;
    logic [5:0]        in_funct;
    logic [DATA_W-1:0] in_rs_val;
    logic [DATA_W-1:0] in_rt_val;
    logic [15:0]       in_imm;
    logic [4:0]        in_rd;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_a;
    logic [DATA_W-1:0] out_b;
    logic              out_bi;
    logic              out_ci;
    logic [1:0]        out_op;
    logic              out_slt;
    logic [4:0]        out_rd;
    logic              out_illegal;

    modport master (
        output in_valid, in_opcode, in_funct, in_rs_val, in_rt_val, in_imm, in_rd,
        output flush, out_ready,
        input  in_ready, out_valid, out_a, out_b, out_bi, out_ci, out_op, out_slt,
        input  out_rd, out_illegal
    );

    modport slave (
        input  in_valid, in_opcode, in_funct, in_rs_val, in_rt_val, in_imm, in_rd,
        input  flush, out_ready,
        output in_ready, out_valid, out_a, out_b, out_bi, out_ci, out_op, out_slt,
        output out_rd, out_illegal
    );

endinterface

// File: rtl/alu_ctrl_dec.sv
// Combinational MIPS opcode/funct decode into ALU controls, operand-b select
// and the extended immediate.
module alu_ctrl_dec
    import mips_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [5:0]        opcode_i,
    input  logic [5:0]        funct_i,
    input  logic [15:0]       imm_i,
    output logic              bi_o,
    output logic              ci_o,
    output alu_op_e           op_o,
    output logic              slt_o,
    output logic              illegal_o,
    output b_sel_e            b_sel_o,
    output logic [DATA_W-1:0] imm_ext_o
);

    ext_mode_e ext_mode;

    always_comb begin
        bi_o      = 1'b0;
        ci_o      = 1'b0;
        op_o      = ALU_AND;
        slt_o     = 1'b0;
        illegal_o = 1'b0;
        b_sel_o   = BSEL_RT;
        ext_mode  = EXT_ZERO;
        unique case (opcode_i)
            OPC_RTYPE: begin
                unique case (funct_i)
                    FUNCT_ADD: op_o = ALU_ADD;
                    FUNCT_SUB: begin op_o = ALU_ADD; bi_o = 1'b1; ci_o = 1'b1; end
                    FUNCT_AND: op_o = ALU_AND;
                    FUNCT_OR:  op_o = ALU_OR;
                    FUNCT_SLT: begin
                        op_o = ALU_ADD; bi_o = 1'b1; ci_o = 1'b1; slt_o = 1'b1;
                    end
                    default:   illegal_o = 1'b1;
                endcase
            end
            OPC_ADDI: begin op_o = ALU_ADD; b_sel_o = BSEL_IMM; ext_mode = EXT_SIGN; end
            OPC_ANDI: begin op_o = ALU_AND; b_sel_o = BSEL_IMM; end
            OPC_ORI:  begin op_o = ALU_OR;  b_sel_o = BSEL_IMM; end
            OPC_SLTI: begin
                op_o = ALU_ADD; bi_o = 1'b1; ci_o = 1'b1; slt_o = 1'b1;
                b_sel_o = BSEL_IMM; ext_mode = EXT_SIGN;
            end
            default:  illegal_o = 1'b1;
        endcase
    end

    assign imm_ext_o = (ext_mode == EXT_SIGN) ? {{(DATA_W-16){imm_i[15]}}, imm_i}
                                              : {{(DATA_W-16){1'b0}}, imm_i};

endmodule

// File: rtl/id_ex_alu_stage.sv
// ID/EX register stage: decodes an instruction into ALU controls and holds it in
// a main register backed by one skid register, so in_ready never waits on out_ready.
module id_ex_alu_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        in_opcode,
    input  logic [5:0]        in_funct,
    input  logic [DATA_W-1:0] in_rs_val,
    input  logic [DATA_W-1:0] in_rt_val,
    input  logic [15:0]       in_imm,
    input  logic [4:0]        in_rd,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic              out_bi,
    output logic              out_ci,
    output logic [1:0]        out_op,
    output logic              out_slt,
    output logic [4:0]        out_rd,
    output logic              out_illegal
);

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic              bi;
        logic              ci;
        alu_op_e           op;
        logic              slt;
        logic [4:0]        rd;
        logic              illegal;
    } beat_t;

    logic              dec_bi;
    logic              dec_ci;
    alu_op_e           dec_op;
    logic              dec_slt;
    logic              dec_illegal;
    b_sel_e            dec_b_sel;
    logic [DATA_W-1:0] dec_imm_ext;
    beat_t             in_beat;

    stage_state_e state_q, state_d;
    beat_t        main_q, main_d;
    beat_t        skid_q, skid_d;
    logic         in_ready_q, in_ready_d;
    logic         in_fire, out_fire;

    alu_ctrl_dec #(.DATA_W(DATA_W)) u_dec (
        .opcode_i  (in_opcode),
        .funct_i   (in_funct),
        .imm_i     (in_imm),
        .bi_o      (dec_bi),
        .ci_o      (dec_ci),
        .op_o      (dec_op),
        .slt_o     (dec_slt),
        .illegal_o (dec_illegal),
        .b_sel_o   (dec_b_sel),
        .imm_ext_o (dec_imm_ext)
    );

    // Illegal instructions still carry their operands, but never a writeback target.
    always_comb begin
        in_beat.a       = in_rs_val;
        in_beat.b       = (dec_b_sel == BSEL_IMM) ? dec_imm_ext : in_rt_val;
        in_beat.bi      = dec_bi;
        in_beat.ci      = dec_ci;
        in_beat.op      = dec_op;
        in_beat.slt     = dec_slt;
        in_beat.rd      = dec_illegal ? 5'd0 : in_rd;
        in_beat.illegal = dec_illegal;
    end

    assign out_valid = (state_q != ST_EMPTY);
    assign in_fire   = in_valid & in_ready_q;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        main_d  = in_beat;
                        state_d = ST_HALF;
                    end
                end
                ST_HALF: begin
                    if (in_fire && out_fire) begin
                        main_d = in_beat;
                    end else if (in_fire) begin
                        skid_d  = in_beat;
                        state_d = ST_FULL;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        main_d  = skid_q;
                        state_d = ST_HALF;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
        in_ready_d = (state_d != ST_FULL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_a       = main_q.a;
    assign out_b       = main_q.b;
    assign out_bi      = main_q.bi;
    assign out_ci      = main_q.ci;
    assign out_op      = main_q.op;
    assign out_slt     = main_q.slt;
    assign out_rd      = main_q.rd;
    assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_id_ex_alu_stage.sv
// Directed bench for id_ex_alu_stage: a decode vector table plus hand-written
// stall, flush and reset sequences.
module tb_id_ex_alu_stage;

    localparam int DATA_W = 32;

    typedef struct {
        logic [5:0]  opc;
        logic [5:0]  fn;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [15:0] imm;
        logic [4:0]  rd;
        logic [31:0] ea;
        logic [31:0] eb;
        logic [1:0]  eop;
        logic        ebi;
        logic        eci;
        logic        eslt;
        logic        eill;
        logic [4:0]  erd;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;

    id_ex_alu_stage_if #(.DATA_W(DATA_W)) bus ();

    id_ex_alu_stage #(.DATA_W(DATA_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (bus.in_valid),
        .in_ready    (bus.in_ready),
        .in_opcode   (bus.in_opcode),
        .in_funct    (bus.in_funct),
        .in_rs_val   (bus.in_rs_val),
        .in_rt_val   (bus.in_rt_val),
        .in_imm      (bus.in_imm),
        .in_rd       (bus.in_rd),
        .flush       (bus.flush),
        .out_valid   (bus.out_valid),
        .out_ready   (bus.out_ready),
        .out_a       (bus.out_a),
        .out_b       (bus.out_b),
        .out_bi      (bus.out_bi),
        .out_ci      (bus.out_ci),
        .out_op      (bus.out_op),
        .out_slt     (bus.out_slt),
        .out_rd      (bus.out_rd),
        .out_illegal (bus.out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [5:0] opc, input logic [5:0] fn,
                                input logic [31:0] rs, input logic [31:0] rt,
                                input logic [15:0] imm, input logic [4:0] rd,
                                input logic [31:0] ea, input logic [31:0] eb,
                                input logic [1:0] eop, input logic ebi, input logic eci,
                                input logic eslt, input logic eill, input logic [4:0] erd);
        vec_t v;
        v.opc = opc; v.fn = fn; v.rs = rs; v.rt = rt; v.imm = imm; v.rd = rd;
        v.ea = ea; v.eb = eb; v.eop = eop; v.ebi = ebi; v.eci = eci;
        v.eslt = eslt; v.eill = eill; v.erd = erd;
        return v;
    endfunction

    // Plain R-type ADD beat tagged by k, used for ordering sequences.
    function automatic vec_t add_beat(input logic [4:0] k);
        logic [31:0] rs;
        logic [31:0] rt;
        rs = {27'd0, k};
        rt = {23'd0, k, 4'h0};
        return mk(6'h00, 6'h20, rs, rt, 16'h0, k, rs, rt, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, k);
    endfunction

    function automatic logic [75:0] exp_of(input vec_t v);
        return {1'b1, v.ea, v.eb, v.ebi, v.eci, v.eop, v.eslt, v.erd, v.eill};
    endfunction

    function automatic logic [75:0] got_bundle();
        return {bus.out_valid, bus.out_a, bus.out_b, bus.out_bi, bus.out_ci,
                bus.out_op, bus.out_slt, bus.out_rd, bus.out_illegal};
    endfunction

    task automatic chk(input string nm, input logic [75:0] got, input logic [75:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end else begin
            $display("ok   %s: %h", nm, got);
        end
    endtask

    task automatic chk_bit(input string nm, input logic got, input logic exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", nm, got, exp);
        end else begin
            $display("ok   %s: %b", nm, got);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.in_opcode = v.opc;
        bus.in_funct  = v.fn;
        bus.in_rs_val = v.rs;
        bus.in_rt_val = v.rt;
        bus.in_imm    = v.imm;
        bus.in_rd     = v.rd;
    endtask

    vec_t vecs[11];

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        vecs[0]  = mk(6'h00, 6'h22, 32'd5, 32'd3, 16'h0000, 5'd7,
                      32'd5, 32'd3, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 5'd7);
        vecs[1]  = mk(6'h00, 6'h20, 32'd10, 32'd20, 16'h0000, 5'd3,
                      32'd10, 32'd20, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 5'd3);
        vecs[2]  = mk(6'h00, 6'h24, 32'h0000F0F0, 32'h00000FF0, 16'h0000, 5'd4,
                      32'h0000F0F0, 32'h00000FF0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 5'd4);
        vecs[3]  = mk(6'h00, 6'h25, 32'h0000F0F0, 32'h00000FF0, 16'h0000, 5'd5,
                      32'h0000F0F0, 32'h00000FF0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 5'd5);
        vecs[4]  = mk(6'h00, 6'h2A, 32'hFFFFFFFF, 32'd1, 16'h0000, 5'd6,
                      32'hFFFFFFFF, 32'd1, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0, 5'd6);
        vecs[5]  = mk(6'h08, 6'h3F, 32'h00000100, 32'h00001234, 16'hFFFF, 5'd8,
                      32'h00000100, 32'hFFFFFFFF, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 5'd8);
        vecs[6]  = mk(6'h0C, 6'h00, 32'h0000ABCD, 32'h00001234, 16'hFFFF, 5'd9,
                      32'h0000ABCD, 32'h0000FFFF, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 5'd9);
        vecs[7]  = mk(6'h0D, 6'h00, 32'h00000001, 32'h00001234, 16'h8001, 5'd10,
                      32'h00000001, 32'h00008001, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 5'd10);
        vecs[8]  = mk(6'h0A, 6'h00, 32'h00000002, 32'h00001234, 16'h8000, 5'd11,
                      32'h00000002, 32'hFFFF8000, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0, 5'd11);
        vecs[9]  = mk(6'h23, 6'h20, 32'd44, 32'd55, 16'h0004, 5'd12,
                      32'd44, 32'd55, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0);
        vecs[10] = mk(6'h00, 6'h21, 32'd1, 32'd2, 16'h0000, 5'd13,
                      32'd1, 32'd2, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0);

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        drive(mk(6'h0, 6'h0, 32'h0, 32'h0, 16'h0, 5'h0, 32'h0, 32'h0, 2'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'h0));
        #12;
        chk("reset_outputs", got_bundle(), 76'd0);
        chk_bit("reset_in_ready", bus.in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        // Decode table: one beat at a time, latency 1, then drained.
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            bus.in_valid  = 1'b1;
            bus.out_ready = 1'b1;
            @(posedge clk); #1;
            chk($sformatf("vec%0d", i), got_bundle(), exp_of(vecs[i]));
            @(negedge clk);
            bus.in_valid = 1'b0;
            @(posedge clk); #1;
            chk_bit($sformatf("vec%0d_drained", i), bus.out_valid, 1'b0);
        end

        // Stall: two beats fill main+skid, third waits; outputs stay on beat 1.
        @(negedge clk);
        bus.out_ready = 1'b0;
        drive(add_beat(5'd1));
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        chk("stall_b1", got_bundle(), exp_of(add_beat(5'd1)));
        chk_bit("stall_half_ready", bus.in_ready, 1'b1);
        @(negedge clk);
        drive(add_beat(5'd2));
        @(posedge clk); #1;
        chk("stall_b1_full", got_bundle(), exp_of(add_beat(5'd1)));
        chk_bit("stall_full_ready", bus.in_ready, 1'b0);
        @(negedge clk);
        drive(add_beat(5'd3));
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk($sformatf("stall_hold%0d", c), got_bundle(), exp_of(add_beat(5'd1)));
            chk_bit($sformatf("stall_hold%0d_ready", c), bus.in_ready, 1'b0);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("release_b2", got_bundle(), exp_of(add_beat(5'd2)));
        chk_bit("release_ready", bus.in_ready, 1'b1);
        @(posedge clk); #1;
        chk("release_b3", got_bundle(), exp_of(add_beat(5'd3)));
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        chk_bit("release_empty", bus.out_valid, 1'b0);

        // Flush from FULL with a same-cycle input beat: everything is discarded.
        @(negedge clk);
        bus.out_ready = 1'b0;
        drive(add_beat(5'd4));
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        drive(add_beat(5'd5));
        @(posedge clk); #1;
        chk_bit("flush_pre_full", bus.in_ready, 1'b0);
        @(negedge clk);
        drive(add_beat(5'd6));
        bus.flush = 1'b1;
        @(posedge clk); #1;
        chk_bit("flush_valid", bus.out_valid, 1'b0);
        chk_bit("flush_ready", bus.in_ready, 1'b1);
        @(negedge clk);
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk_bit($sformatf("flush_no_stale%0d", c), bus.out_valid, 1'b0);
        end

        // Asynchronous reset while HALF, then a fresh beat with latency 1.
        @(negedge clk);
        bus.out_ready = 1'b0;
        drive(add_beat(5'd7));
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        chk("rst_pre_half", got_bundle(), exp_of(add_beat(5'd7)));
        @(negedge clk);
        bus.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_outputs", got_bundle(), 76'd0);
        chk_bit("rst_async_ready", bus.in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        drive(add_beat(5'd8));
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        chk("rst_after_b8", got_bundle(), exp_of(add_beat(5'd8)));
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        chk_bit("rst_after_drained", bus.out_valid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
